// File: rtl/zoom_in_controlador_if.sv
// Bundle between the zoom-in sequencer and its surroundings: host control,
// replication datapath coordinates and the source/destination framebuffer ports.
interface zoom_in_controlador_if #(
    parameter int LARG_PIXEL = 8
);
    logic                  iniciar;
    logic [1:0]            fator_zoom;
    logic                  ocupado;
    logic                  concluido;
    logic [1:0]            fator_zoom_dp;
    logic [9:0]            x_destino;
    logic [9:0]            y_destino;
    logic [9:0]            x_fonte;
    logic [9:0]            y_fonte;
    logic                  rd_en;
    logic [15:0]           rd_addr;
    logic [LARG_PIXEL-1:0] rd_dado;
    logic                  wr_en;
    logic [19:0]           wr_addr;
    logic [LARG_PIXEL-1:0] wr_dado;
    logic                  wr_pronto;

    modport master (
        input  iniciar, fator_zoom, x_fonte, y_fonte, rd_dado, wr_pronto,
        output ocupado, concluido, fator_zoom_dp, x_destino, y_destino,
               rd_en, rd_addr, wr_en, wr_addr, wr_dado
    );

    modport slave (
        output iniciar, fator_zoom, x_fonte, y_fonte, rd_dado, wr_pronto,
        input  ocupado, concluido, fator_zoom_dp, x_destino, y_destino,
               rd_en, rd_addr, wr_en, wr_addr, wr_dado
    );
endinterface

// File: rtl/zoom_in_controlador.sv
// Raster-order sequencer for pixel-replication zoom-in: read one source pixel,
// then write it to the packed destination framebuffer, honouring write backpressure.
module zoom_in_controlador #(
    parameter int LARG_FONTE = 160,
    parameter int ALT_FONTE  = 120,
    parameter int LARG_PIXEL = 8
) (
    input logic                   clk,
    input logic                   reset,
    zoom_in_controlador_if.master bus
);

    typedef enum logic [2:0] {OCIOSO, LER, ESPERA, ESCREVER, FIM} estado_t;

    estado_t               estado;
    estado_t               estado_prox;
    logic [1:0]            fator_q;
    logic [9:0]            x_q;
    logic [9:0]            y_q;
    logic [LARG_PIXEL-1:0] wr_dado_q;
    logic [1:0]            desl;
    logic [10:0]           larg_dest;
    logic [10:0]           alt_dest;
    logic                  ult_x;
    logic                  ult_y;

    // Destination size is 11 bits wide: a 256-pixel source at 4x reaches exactly 1024.
    always_comb begin
        case (fator_q)
            2'b01:   desl = 2'd1;
            2'b10:   desl = 2'd2;
            default: desl = 2'd0;
        endcase
        larg_dest = 11'(LARG_FONTE) << desl;
        alt_dest  = 11'(ALT_FONTE) << desl;
        ult_x     = ({1'b0, x_q} == (larg_dest - 11'd1));
        ult_y     = ({1'b0, y_q} == (alt_dest - 11'd1));
    end

    always_ff @(posedge clk) begin
        if (!reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:   if (bus.iniciar) estado_prox = LER;
            LER:      estado_prox = ESPERA;
            ESPERA:   estado_prox = ESCREVER;
            ESCREVER: if (bus.wr_pronto) estado_prox = (ult_x && ult_y) ? FIM : LER;
            FIM:      estado_prox = OCIOSO;
            default:  estado_prox = OCIOSO;
        endcase
    end

    // Counters only advance on an accepted write, so a stalled write keeps its address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fator_q   <= 2'b00;
            x_q       <= 10'd0;
            y_q       <= 10'd0;
            wr_dado_q <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (bus.iniciar) begin
                        fator_q <= bus.fator_zoom;
                        x_q     <= 10'd0;
                        y_q     <= 10'd0;
                    end
                end
                ESPERA: wr_dado_q <= bus.rd_dado;
                ESCREVER: begin
                    if (bus.wr_pronto && !(ult_x && ult_y)) begin
                        if (ult_x) begin
                            x_q <= 10'd0;
                            y_q <= y_q + 10'd1;
                        end else begin
                            x_q <= x_q + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_en     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.ocupado   = 1'b0;
        bus.concluido = 1'b0;
        case (estado)
            LER: begin
                bus.rd_en   = 1'b1;
                bus.ocupado = 1'b1;
            end
            ESPERA:   bus.ocupado = 1'b1;
            ESCREVER: begin
                bus.wr_en   = 1'b1;
                bus.ocupado = 1'b1;
            end
            FIM:      bus.concluido = 1'b1;
            default:  ;
        endcase
    end

    assign bus.fator_zoom_dp = fator_q;
    assign bus.x_destino     = x_q;
    assign bus.y_destino     = y_q;
    assign bus.wr_dado       = wr_dado_q;
    assign bus.rd_addr       = 16'(bus.y_fonte) * 16'(LARG_FONTE) + 16'(bus.x_fonte);
    assign bus.wr_addr       = 20'(y_q) * 20'(larg_dest) + 20'(x_q);

endmodule

// File: tb/tb_zoom_in_controlador.sv
// Scoreboard bench for zoom_in_controlador on a 4x3 source whose RAM holds source[a] = a;
// expected writes are queued at start of each scan and popped as writes are accepted.
module tb_zoom_in_controlador;

    localparam int LF = 4;
    localparam int AF = 3;
    localparam int LP = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_addr[$];
    int   exp_data[$];

    zoom_in_controlador_if #(.LARG_PIXEL(LP)) bus ();

    zoom_in_controlador #(
        .LARG_FONTE(LF),
        .ALT_FONTE (AF),
        .LARG_PIXEL(LP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int desl_de(input logic [1:0] f);
        return (f == 2'b01) ? 1 : (f == 2'b10) ? 2 : 0;
    endfunction

    // Replication datapath and source RAM with one cycle of read latency.
    assign bus.x_fonte = bus.x_destino >> desl_de(bus.fator_zoom_dp);
    assign bus.y_fonte = bus.y_destino >> desl_de(bus.fator_zoom_dp);

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_dado <= bus.rd_addr[7:0];
    end

    task automatic test_reset();
        reset          = 1'b0;
        bus.iniciar    = 1'b0;
        bus.fator_zoom = 2'b10;
        bus.wr_pronto  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.ocupado, bus.concluido, bus.rd_en, bus.wr_en} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_ctrl: got %b expected 0000",
                         {bus.ocupado, bus.concluido, bus.rd_en, bus.wr_en});
            end
            checks++;
            if ({bus.fator_zoom_dp, bus.x_destino, bus.y_destino} !== 22'd0) begin
                errors++;
                $display("[TB] FAIL reset_coord: fator %0d x %0d y %0d expected all 0",
                         bus.fator_zoom_dp, bus.x_destino, bus.y_destino);
            end
            checks++;
            if (bus.wr_dado !== 8'd0 || bus.wr_addr !== 20'd0 || bus.rd_addr !== 16'd0) begin
                errors++;
                $display("[TB] FAIL reset_addr: wr_dado %0d wr_addr %0d rd_addr %0d expected 0",
                         bus.wr_dado, bus.wr_addr, bus.rd_addr);
            end
            bus.iniciar = ~bus.iniciar;
        end
        @(negedge clk);
        reset       = 1'b1;
        bus.iniciar = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ocupado !== 1'b0 || bus.rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_wins: ocupado %b rd_en %b expected 0 0", bus.ocupado, bus.rd_en);
        end
    endtask

    task automatic run_scan(input logic [1:0] fz, input int stall_pix, input int stall_len,
                            input bit change_fz, input bit poke, input int chk_x,
                            input int chk_y, input int chk_rd, input string name);
        int s, w, h, n, budget, writes, reads, busy, pulses, done_at, stalled;
        bit chk_seen;
        s = desl_de(fz);
        w = LF << s;
        h = AF << s;
        n = w * h;
        exp_addr.delete();
        exp_data.delete();
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                exp_addr.push_back(y * w + x);
                exp_data.push_back((y >> s) * LF + (x >> s));
            end
        writes = 0; reads = 0; busy = 0; pulses = 0; done_at = -1; stalled = 0; chk_seen = 1'b0;
        budget = 3 * n + stall_len + 10;
        @(negedge clk);
        bus.iniciar    = 1'b1;
        bus.fator_zoom = fz;
        bus.wr_pronto  = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            bus.iniciar = poke && (c == 4 || c == 20);
            if (change_fz && c >= 5) bus.fator_zoom = 2'b00;
            if (bus.ocupado) busy++;
            if (bus.concluido) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
            if (bus.rd_en) begin
                reads++;
                if (bus.x_destino == chk_x && bus.y_destino == chk_y) begin
                    chk_seen = 1'b1;
                    checks++;
                    if (bus.rd_addr !== 16'(chk_rd)) begin
                        errors++;
                        $display("[TB] FAIL %s rd_addr at (%0d,%0d): got %0d expected %0d",
                                 name, chk_x, chk_y, bus.rd_addr, chk_rd);
                    end
                end
            end
            bus.wr_pronto = 1'b1;
            if (bus.wr_en) begin
                checks++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL %s extra write: wr_addr %0d, none expected", name, bus.wr_addr);
                end else if (bus.wr_addr !== 20'(exp_addr[0]) || bus.wr_dado !== 8'(exp_data[0])) begin
                    errors++;
                    $display("[TB] FAIL %s write: got addr %0d data %0d expected addr %0d data %0d",
                             name, bus.wr_addr, bus.wr_dado, exp_addr[0], exp_data[0]);
                end
                if (writes == stall_pix && stalled < stall_len) begin
                    bus.wr_pronto = 1'b0;
                    stalled++;
                end else begin
                    writes++;
                    if (exp_addr.size() > 0) begin
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                    end
                end
            end
            if (done_at > 0 && c >= done_at + 2) break;
        end
        bus.iniciar = 1'b0;
        checks++;
        if (writes != n || reads != n) begin
            errors++;
            $display("[TB] FAIL %s counts: writes %0d reads %0d expected %0d each", name, writes, reads, n);
        end
        checks++;
        if (done_at != 3 * n + 1 + stall_len || pulses != 1) begin
            errors++;
            $display("[TB] FAIL %s concluido: cycle %0d pulses %0d expected cycle %0d pulses 1",
                     name, done_at, pulses, 3 * n + 1 + stall_len);
        end
        checks++;
        if (busy != 3 * n + stall_len) begin
            errors++;
            $display("[TB] FAIL %s ocupado: got %0d cycles expected %0d", name, busy, 3 * n + stall_len);
        end
        if (chk_x >= 0) begin
            checks++;
            if (!chk_seen) begin
                errors++;
                $display("[TB] FAIL %s probe: coordinate (%0d,%0d) never read, expected 1 read",
                         name, chk_x, chk_y);
            end
        end
    endtask

    task automatic test_scan_1x();
        run_scan(2'b00, -1, 0, 1'b0, 1'b0, -1, -1, 0, "scan_1x");
    endtask

    task automatic test_scan_2x();
        run_scan(2'b01, -1, 0, 1'b0, 1'b0, 5, 3, 6, "scan_2x");
    endtask

    task automatic test_scan_4x();
        run_scan(2'b10, -1, 0, 1'b1, 1'b0, 15, 11, 11, "scan_4x");
    endtask

    task automatic test_backpressure();
        run_scan(2'b00, 2, 5, 1'b0, 1'b0, -1, -1, 0, "backpressure");
    endtask

    task automatic test_reset_mid_run();
        bit found;
        int sneak;
        found = 1'b0;
        sneak = 0;
        @(negedge clk);
        bus.iniciar    = 1'b1;
        bus.fator_zoom = 2'b01;
        bus.wr_pronto  = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.iniciar = 1'b0;
            if (bus.wr_en && bus.wr_addr == 20'd7) begin
                found         = 1'b1;
                bus.wr_pronto = 1'b0;
                reset         = 1'b0;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL abort_reach: write of pixel 7 seen %b expected 1", found);
        end
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if ({bus.wr_en, bus.rd_en, bus.ocupado, bus.fator_zoom_dp} !== 5'd0 ||
            bus.x_destino !== 10'd0 || bus.y_destino !== 10'd0) begin
            errors++;
            $display("[TB] FAIL abort_state: wr_en %b rd_en %b ocupado %b fator %0d x %0d y %0d expected all 0",
                     bus.wr_en, bus.rd_en, bus.ocupado, bus.fator_zoom_dp, bus.x_destino, bus.y_destino);
        end
        bus.wr_pronto = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.wr_en || bus.rd_en || bus.ocupado) sneak++;
        end
        checks++;
        if (sneak != 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: %0d active cycles after reset, expected 0", sneak);
        end
    endtask

    task automatic test_restart();
        run_scan(2'b11, -1, 0, 1'b0, 1'b1, -1, -1, 0, "restart");
    endtask

    initial begin
        test_reset();
        test_scan_1x();
        test_scan_2x();
        test_scan_4x();
        test_backpressure();
        test_reset_mid_run();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zoom_in_controlador.md
# zoom_in_controlador

Sequencer for the pixel-replication zoom-in datapath. On a start pulse it scans every destination coordinate of the zoomed image in raster order and drives `x_destino`/`y_destino` into the replication datapath. It reads the returned source pixel from the source framebuffer and writes it to the destination framebuffer with write backpressure. It sits between the host/control register file and the two framebuffer memories.

## Interface
- `LARG_FONTE`, 160: source image width in pixels (≤ 256).
- `ALT_FONTE`, 120: source image height in pixels (≤ 256).
- `LARG_PIXEL`, 8: pixel data width.
- `clk  in  1`: single clock; all logic on rising edge.
- `reset  in  1`: synchronous, active-low.
- `iniciar  in  1`: start pulse; sampled only in OCIOSO.
- `fator_zoom  in  2`: 00 = 1x, 01 = 2x, 10 = 4x, 11 = 1x; latched at start.
- `ocupado  out  1`: high from the first LER cycle through the final write.
- `concluido  out  1`: one-cycle pulse after the last write is accepted.
- `fator_zoom_dp  out  2`: latched factor, driven to the replication datapath.
- `x_destino`, `y_destino  out  10`: registered scan coordinates, driven to the datapath.
- `x_fonte`, `y_fonte  in  10`: combinational source coordinates from the datapath.
- `rd_en  out  1`, `rd_addr  out  16`: source read; `rd_addr = y_fonte*LARG_FONTE + x_fonte`.
- `rd_dado  in  LARG_PIXEL`: source pixel, valid the cycle after `rd_en`.
- `wr_en  out  1`, `wr_addr  out  20`, `wr_dado  out  LARG_PIXEL`: destination write.
- `wr_pronto  in  1`: destination accepts the write when `wr_en & wr_pronto`.

## Operation
- Shift `s`: 0 for factor 00/11, 1 for 01, 2 for 10, computed from the latched factor.
- Destination size: `LARG_DEST = LARG_FONTE << s`, `ALT_DEST = ALT_FONTE << s`.
- Destination addressing is packed: `wr_addr = y_destino*LARG_DEST + x_destino`.
- States:
  - OCIOSO: idle.
    - `iniciar=1`: latch `fator_zoom`, clear counters, go to LER.
  - LER: `rd_en=1` for exactly one cycle; go to ESPERA.
  - ESPERA: register `rd_dado` into `wr_dado`; go to ESCREVER.
  - ESCREVER: `wr_en=1`; hold `wr_addr`/`wr_dado` stable.
    - `wr_pronto=1`: write accepted.
    - If `x_destino == LARG_DEST-1` and `y_destino == ALT_DEST-1`, go to FIM.
    - Else if `x_destino == LARG_DEST-1`, set x←0, y←y+1, go to LER.
    - Else x←x+1, go to LER.
    - `wr_pronto=0`: stay in ESCREVER; no counter change.
  - FIM: `concluido=1` for one cycle, `ocupado=0`; go to OCIOSO.
- `iniciar` is ignored outside OCIOSO.
- `fator_zoom` changes during a run are ignored; the latched value is used.
- `iniciar` and `reset` asserted in the same cycle: reset wins.
- Reset mid-operation: next state OCIOSO, no further `rd_en`/`wr_en`, and the partial image is left as written.
- Arithmetic:
  - Products are unsigned and zero-extended to the address width.
  - Counters are 10 bit; `LARG_DEST`/`ALT_DEST` never exceed 1024 under the parameter limits.

## Timing
- Reset values:
  - State is OCIOSO.
  - `ocupado`, `concluido`, `rd_en`, `wr_en`, `fator_zoom_dp`, `x_destino`, `y_destino` and `wr_dado` are 0.
  - `wr_addr` is 0.
  - `rd_addr` follows the datapath, which is 0 at coordinate 0.
- `iniciar` is sampled at edge k. Cycle k+1 is LER, with `ocupado=1` and `rd_en=1` for coordinate (0,0).
- Read latency is one cycle:
  - The address is presented in LER.
  - Data is valid in ESPERA and captured at the ESPERA→ESCREVER edge.
- Minimum cost is 3 cycles per destination pixel. Each stalled ESCREVER cycle adds 1.
- No stalls: the last write is accepted in cycle k+3·N, with N = LARG_DEST·ALT_DEST. `concluido` is high in cycle k+3·N+1.
- `x_fonte`/`y_fonte` are treated as combinational from `x_destino`/`y_destino` within the same cycle.

## Test plan
Benches use `LARG_FONTE=4`, `ALT_FONTE=3`, with a RAM model where `source[a] = a`.
- Reset: hold `reset=0` 3 cycles, toggling `iniciar` → all outputs 0, state OCIOSO, no `wr_en`.
- 1x, `wr_pronto=1`, `iniciar` at edge k → 12 writes with `wr_addr` 0..11 and `wr_dado` == `wr_addr`; `concluido` pulses in cycle k+37; `ocupado` is high for 36 cycles.
- 2x → 48 writes over 8x6. For destination (5,3): `rd_addr` = 6, `wr_addr` = 29, `wr_dado` = 6. Every 2x2 block carries equal data.
- 4x → 192 writes over 16x12. Last write: `wr_addr` = 191, `rd_addr` = 11. Changing `fator_zoom` to 00 mid-run has no effect.
- Backpressure: `wr_pronto=0` for 5 cycles at pixel 2 under 1x → `wr_en`, `wr_addr` = 2 and `wr_dado` = 2 stay stable for 6 cycles; no extra `rd_en`; `concluido` arrives 5 cycles later.
- `reset=0` during ESCREVER of pixel 7 → no further writes; a fresh `iniciar` restarts at `wr_addr` 0; `iniciar` pulses while `ocupado=1` are ignored.
